// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the multi-master byte-wide memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RD_TAIL = 2'd2
  } state_e;

  localparam int MAX_MASTERS = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (oh[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin picker: first requester at or after ptr, wrapping through all N bits.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    grant = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master arbiter for the byte-wide memory port: multi-byte reads/writes issued one
// byte per cycle, master 0 has absolute priority, the rest share round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic [NUM_MASTERS-1:0]    req_valid,
  input  logic [NUM_MASTERS-1:0]    req_wr,
  input  logic [2*NUM_MASTERS-1:0]  req_len,
  input  logic [32*NUM_MASTERS-1:0] req_addr,
  input  logic [32*NUM_MASTERS-1:0] req_wdata,
  output logic [NUM_MASTERS-1:0]    req_ready,
  output logic [NUM_MASTERS-1:0]    resp_valid,
  output logic [31:0]               resp_rdata,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  output logic [7:0]                mem_dout,
  input  logic [7:0]                mem_din,
  output logic                      io_en
);

  localparam int PW = $clog2(NUM_MASTERS);

  state_e           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       len_q, len_d;
  logic             wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       i_q, i_d;
  logic [1:0]       c_q, c_d;
  logic             issued_q, issued_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             resp_valid_q, resp_valid_d;

  logic [NUM_MASTERS-1:0] rr_req, rr_grant, win_oh;
  logic [2:0]             win_idx;
  logic                   grant_ok;
  int                     w;

  rr_arbiter #(.N(NUM_MASTERS), .PW(PW)) u_rr (
    .req   (rr_req),
    .ptr   (rr_ptr_q),
    .grant (rr_grant)
  );

  always_comb begin
    rr_req    = req_valid;
    rr_req[0] = 1'b0;
    win_oh    = req_valid[0] ? NUM_MASTERS'(1) : rr_grant;
    win_idx   = onehot_to_idx(MAX_MASTERS'(win_oh));
    w         = int'(win_idx);
    // The resp_valid cycle is kept free of grants so the two pulses never coincide.
    grant_ok  = rst_n_in && rdy_in && (state_q == ST_IDLE) && !resp_valid_q && (|req_valid);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    addr_d       = addr_q;
    len_d        = len_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    i_d          = i_q;
    c_d          = c_q;
    issued_d     = issued_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;

    // The byte issued last cycle lands one cycle later, only if both cycles were ready.
    if ((state_q != ST_IDLE) && rdy_in && issued_q) begin
      rdata_d[8*c_q +: 8] = mem_din;
      c_d                 = c_q + 2'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          owner_d  = win_idx;
          addr_d   = req_addr[32*w +: 32];
          len_d    = req_len[2*w +: 2];
          wr_d     = req_wr[w];
          wdata_d  = req_wdata[32*w +: 32];
          i_d      = '0;
          c_d      = '0;
          issued_d = 1'b0;
          rdata_d  = '0;
          state_d  = ST_XFER;
          if (w != 0) begin
            rr_ptr_d = (w == NUM_MASTERS - 1) ? PW'(1) : PW'(w + 1);
          end
        end
      end
      ST_XFER: begin
        if (rdy_in) begin
          issued_d = !wr_q;
          i_d      = i_q + 2'd1;
          if (i_q == len_q) begin
            state_d      = wr_q ? ST_IDLE : ST_RD_TAIL;
            resp_valid_d = wr_q;
          end
        end else begin
          // Rewind a read to the first un-captured byte; strobed write bytes stay done.
          issued_d = 1'b0;
          if (!wr_q) i_d = c_q;
        end
      end
      ST_RD_TAIL: begin
        issued_d = 1'b0;
        if (rdy_in) begin
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          i_d     = c_q;
          state_d = ST_XFER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = grant_ok ? win_oh : '0;
    resp_valid = resp_valid_q ? (NUM_MASTERS'(1) << owner_q) : '0;
    resp_rdata = resp_valid_q ? rdata_q : '0;
    mem_a      = (state_q == ST_XFER) ? (addr_q + 32'(i_q)) : '0;
    io_en      = mem_a[RAM_ADDR_WIDTH];
    mem_wr     = (state_q == ST_XFER) && wr_q && rdy_in;
    mem_dout   = mem_wr ? wdata_q[8*i_q +: 8] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= PW'(1);
      addr_q       <= '0;
      len_q        <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      i_q          <= '0;
      c_q          <= '0;
      issued_q     <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      i_q          <= i_d;
      c_q          <= c_d;
      issued_q     <= issued_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random single-master transfers checked
// against a byte-array memory reference and a priority/round-robin grant model.
module tb_mem_port_arbiter;

  localparam int N   = 3;
  localparam int RAW = 17;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            rdy_in;
  logic [N-1:0]    req_valid, req_wr;
  logic [2*N-1:0]  req_len;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [N-1:0]    req_ready, resp_valid;
  logic [31:0]     resp_rdata, mem_a;
  logic            mem_wr, io_en;
  logic [7:0]      mem_dout, mem_din;

  int checks = 0;
  int errors = 0;
  int rr_last;

  logic [7:0] env_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_port_arbiter #(.NUM_MASTERS(N), .RAM_ADDR_WIDTH(RAW)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_len    (req_len),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_a      (mem_a),
    .mem_wr     (mem_wr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .io_en      (io_en)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Synchronous byte memory behind the port.
  always @(posedge clk_in) begin
    mem_din <= env_rd(mem_a);
    if (mem_wr) env_mem[mem_a] = mem_dout;
  end

  // Master 0 first; otherwise the next valid master after the last non-0 winner.
  function automatic int exp_winner(input logic [N-1:0] valid);
    int m;
    if (valid[0]) return 0;
    for (int k = 1; k < N; k++) begin
      m = ((rr_last - 1 + k) % (N - 1)) + 1;
      if (valid[m]) return m;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int m);
    logic [N-1:0] v;
    v = '0;
    if (m >= 0) v[m] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int m, input bit wr, input int len,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[m]           = 1'b1;
    req_wr[m]              = wr;
    req_len[2*m +: 2]      = 2'(len);
    req_addr[32*m +: 32]   = addr;
    req_wdata[32*m +: 32]  = wdata;
  endtask

  task automatic wait_grant();
    int waited;
    waited = 0;
    while (req_ready === '0 && waited < 40) begin
      @(negedge clk_in); #1;
      waited++;
    end
  endtask

  // One complete transfer with rdy_in held high; checks grant, every issued byte, latency and data.
  task automatic run_txn(input int m, input bit wr, input int len,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int          n;
    logic [31:0] a, exp_rd;
    n      = len + 1;
    exp_rd = '0;
    for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_rd(addr + 32'(k));
    @(negedge clk_in);
    drive_req(m, wr, len, addr, wdata);
    #1;
    wait_grant();
    check("grant", req_ready, onehot(m));
    if (m != 0) rr_last = m;
    if (wr) for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      if (k == 0) req_valid[m] = 1'b0;
      #1;
      a = addr + 32'(k);
      check("mem_a", mem_a, a);
      check("io_en", io_en, a[RAW]);
      check("mem_wr", mem_wr, wr);
      if (wr) check("mem_dout", mem_dout, wdata[8*k +: 8]);
    end
    if (!wr) begin
      @(negedge clk_in); #1;
      check("resp_early", resp_valid, '0);
    end
    @(negedge clk_in); #1;
    check("resp_valid", resp_valid, onehot(m));
    if (!wr) check("resp_rdata", resp_rdata, exp_rd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gcount, w, sel, len;
    logic [31:0] addr;
    logic [N-1:0] vsnap;

    rst_n_in  = 1'b0;
    rdy_in    = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_len   = '0;
    req_addr  = '0;
    req_wdata = '0;
    rr_last   = N - 1;
    for (int k = 0; k < 4; k++) begin
      env_mem[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
      ref_mem[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
    end

    // Reset state
    #1;
    check("rst_ctl", {req_ready, resp_valid, mem_wr, io_en, mem_dout}, '0);
    check("rst_addr", {resp_rdata, mem_a}, '0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("idle_quiet", {req_ready, resp_valid, mem_wr, mem_a}, '0);

    // Reset asserted mid-write: outputs drop at once, strobed bytes remain
    @(negedge clk_in);
    drive_req(2, 1'b1, 3, 32'h3000, 32'hCAFE_F00D);
    #1;
    wait_grant();
    check("t1_grant", req_ready, onehot(2));
    @(negedge clk_in); #1;
    check("t1_b0", {mem_wr, mem_a}, {1'b1, 32'h3000});
    @(negedge clk_in); #1;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("t1_rst_ctl", {req_ready, resp_valid, mem_wr, io_en, mem_dout}, '0);
    check("t1_rst_addr", {resp_rdata, mem_a}, '0);
    ref_mem[32'h3000] = 8'h0D;
    ref_mem[32'h3001] = 8'hF0;
    rr_last = N - 1;
    @(negedge clk_in); #1;
    check("t1_rst_hold", {req_ready, mem_wr, mem_a}, '0);
    @(negedge clk_in);
    rst_n_in     = 1'b1;
    req_valid[2] = 1'b0;
    run_txn(1, 1'b0, 1, 32'h3000, 32'h0);

    // 4 B read of preloaded RAM, 2 B write across the RAM/IO boundary, wrapping read
    run_txn(1, 1'b0, 3, 32'h0000_0100, 32'h0);
    run_txn(2, 1'b1, 1, 32'h0001_FFFF, 32'h0000_BEEF);
    run_txn(1, 1'b0, 1, 32'h0001_FFFF, 32'h0);
    run_txn(1, 1'b0, 1, 32'hFFFF_FFFF, 32'h0);

    // No grant while paused
    @(negedge clk_in);
    rdy_in = 1'b0;
    drive_req(2, 1'b0, 0, 32'h200, 32'h0);
    #1;
    check("pause_nogrant0", req_ready, '0);
    @(negedge clk_in); #1;
    check("pause_nogrant1", req_ready, '0);
    @(negedge clk_in);
    req_valid[2] = 1'b0;
    rdy_in       = 1'b1;

    // Pause after byte 1 of a 4 B read: byte 1 re-issued, response 4 cycles late
    @(negedge clk_in);
    drive_req(1, 1'b0, 3, 32'h100, 32'h0);
    #1;
    wait_grant();
    check("t5_grant", req_ready, onehot(1));
    rr_last = 1;
    @(negedge clk_in); req_valid[1] = 1'b0; #1;
    check("t5_b0", mem_a, 32'h100);
    @(negedge clk_in); #1;
    check("t5_b1", mem_a, 32'h101);
    @(negedge clk_in); rdy_in = 1'b0; #1;
    check("t5_pause_wr", mem_wr, 1'b0);
    repeat (2) begin @(negedge clk_in); #1; end
    @(negedge clk_in); rdy_in = 1'b1; #1;
    check("t5_reissue", mem_a, 32'h101);
    @(negedge clk_in); #1;
    check("t5_b2", mem_a, 32'h102);
    @(negedge clk_in); #1;
    check("t5_b3", mem_a, 32'h103);
    @(negedge clk_in); #1;
    check("t5_resp_early", resp_valid, '0);
    @(negedge clk_in); #1;
    check("t5_resp", resp_valid, onehot(1));
    check("t5_rdata", resp_rdata, 32'h4433_2211);

    // All masters requesting: master 0 dominates, then 1 and 2 take turns
    @(negedge clk_in);
    for (int m = 0; m < N; m++) drive_req(m, 1'b0, 0, 32'h400 + 32'(m), 32'h0);
    gcount = 0;
    for (int cyc = 0; cyc < 200 && gcount < 7; cyc++) begin
      @(negedge clk_in);
      if (gcount == 3) req_valid[0] = 1'b0;
      #1;
      check("no_overlap", (|req_ready) & (|resp_valid), 1'b0);
      if (|req_ready) begin
        vsnap = req_valid;
        w = exp_winner(vsnap);
        check("arb", req_ready, onehot(w));
        if (w > 0) rr_last = w;
        gcount++;
      end
    end
    check("arb_count", 32'(gcount), 32'd7);
    @(negedge clk_in);
    req_valid = '0;

    // Random single-master traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 2);
      len = $urandom_range(0, 3);
      if (sel == 0)      addr = 32'h0001_FFF8 + $urandom_range(0, 15);
      else if (sel == 1) addr = 32'h0000_0100 + $urandom_range(0, 15);
      else               addr = 32'hFFFF_FFFC + $urandom_range(0, 3);
      run_txn($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), len, addr, $urandom);
    end

    repeat (2) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
